modadd_seq: RTL and testbench
=============================

// Module: modadd_seq
// PURPOSE
//  Initiator side of the mpadder start/subtract/done handshake: sequences one or two multi-precision
//  adder operations to compute r = (a + b) mod M or r = (a - b) mod M.
//  Sits between the Montgomery datapath controller and a shared external mpadder instance.
//  Owns the adder's request port; the adder itself lives outside this block.
// PARAMETERS
//  W        1027  operand width; adder result width is W+1
//  TIMEOUT  64    max cycles to wait for add_done per request; 0 disables the watchdog
// PORTS
//  clk           in   1    clock
//  resetn        in   1    reset, synchronous, active-low
//  start         in   1    request pulse; sampled only in IDLE
//  subtract      in   1    0: (a+b) mod M, 1: (a-b) mod M
//  in_a          in   W    operand a, requires a < M
//  in_b          in   W    operand b, requires b < M
//  in_m          in   W    modulus M, requires M[W-1]=0 and M>0
//  result        out  W    modular result, registered
//  done          out  1    one-cycle completion pulse
//  err           out  1    valid with done; 1 = adder timeout
//  busy          out  1    high from the cycle after start until the done cycle inclusive
//  add_start     out  1    one-cycle request pulse to the adder
//  add_subtract  out  1    adder mode
//  add_a         out  W    adder operand a
//  add_b         out  W    adder operand b
//  add_result    in   W+1  adder result; bit W = carry XOR subtract (1 = negative on subtract)
//  add_done      in   1    adder completion pulse
// BEHAVIOUR
//  Reset: result=0, done=0, err=0, busy=0, add_start=0, add_subtract=0, add_a=0, add_b=0, state IDLE.
//  Reset is honoured in any state: an in-flight adder op is abandoned and its add_done ignored.
//  States:
//   IDLE     -> REQ1 on start; latch a, b, M and the op mode.
//   REQ1     add_start=1 for one cycle; add_a=a, add_b=b, add_subtract=mode -> WAIT1.
//   WAIT1    on add_done: latch s=add_result.
//            Add mode -> REQ2 (operation s[W-1:0] - M).
//            Sub mode, s[W]=1 -> REQ2 (operation s[W-1:0] + M).
//            Sub mode, s[W]=0 -> FIN with r=s[W-1:0].
//   REQ2     add_start=1 for one cycle with the second operation -> WAIT2.
//   WAIT2    on add_done: latch t. Add mode: r = t[W] ? s[W-1:0] : t[W-1:0]. Sub mode: r = t[W-1:0]. -> FIN.
//   FIN      result<=r, done=1, err=0 -> IDLE.
//   TIMEOUT  entered from WAIT1/WAIT2 when the watchdog expires: result<=0, done=1, err=1 -> IDLE.
//  Watchdog: counter cleared on each REQ state and incremented each WAIT cycle.
//   Expiry when the count reaches TIMEOUT with no add_done. add_done in that same cycle wins.
//  Handshake rules:
//   add_a, add_b and add_subtract are held stable from the add_start cycle until add_done.
//   add_done outside WAIT1/WAIT2 is ignored.
//   start while busy is ignored (no queueing). start in the FIN cycle is also ignored.
//  Latency: let L = cycles from add_start to add_done.
//   Two-op path: done at cycle 2L+3 after start is sampled.
//   Sub path with no correction: done at cycle L+2.
//  Width rules:
//   a+b < 2M < 2^W, so s fits in W bits and s[W]=0.
//   Equality case a+b=M yields t=0 with t[W]=0, so r=0.
//  result holds its value until the next done. Out-of-range operands are not checked: result unspecified, done still pulses.
// STRUCTURE
//  Shared package: MP_W=1027, the state encoding enum, and the default TIMEOUT constant.
//  One sub-module: modadd_wdog (TIMEOUT counter with clear/enable/expired); the FSM and datapath stay in modadd_seq.
// TESTING  (bench uses W=16 plus a behavioural adder model with configurable L; one pass at W=1027, L=2)
//  Add wrap:     M=13, a=9, b=7, sub=0 -> two add_start pulses (add, then sub 16-13); result=3, err=0, done at 2L+3.
//  Add boundary: M=13, a=12, b=1 -> result=0. Then a=5, b=4 -> t negative, result=9.
//  Sub borrow:   M=13, a=3, b=9, sub=1 -> second op is an add; result=7.
//  Sub no borrow: M=13, a=9, b=3 -> exactly one add_start; result=6; done at L+2.
//  Timeout:      adder model never asserts add_done, TIMEOUT=8 -> done=1, err=1, result=0 nine cycles after REQ1.
//                The next request then completes normally.
//  Reset and overlap:
//   start again during WAIT1 -> ignored, and only that op's result is returned.
//   resetn=0 during WAIT2 -> all outputs 0 next cycle; the late add_done is ignored; no done pulse.

Source files
------------

// File: rtl/modadd_seq_pkg.sv
// modadd_seq_pkg: shared operand width, default watchdog limit and FSM encoding for modadd_seq
package modadd_seq_pkg;
  localparam int MP_W = 1027;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_FIN   = 3'd5,
    S_TO    = 3'd6
  } state_e;
endpackage

// File: rtl/modadd_wdog.sv
// modadd_wdog: per-request adder watchdog; expires after TIMEOUT enabled cycles, 0 disables it
module modadd_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !resetn ? '0 : cnt_d;
  assign expired_o = (TIMEOUT != 0) && en_i && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/modadd_seq.sv
// modadd_seq: drives a shared mpadder through one or two requests to form (a +/- b) mod M
module modadd_seq
  import modadd_seq_pkg::*;
#(
  parameter int W = MP_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
  logic sub_q, sub_d, mode_q, mode_d, waiting, expired;
  assign waiting = state_q == S_WAIT1 || state_q == S_WAIT2;
  modadd_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .resetn(resetn),
    .clr_i(add_start),
    .en_i(waiting),
    .expired_o(expired)
  );
  // a_q doubles as the saved first sum s while the second request is in flight
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    res_d = res_q;
    sub_d = sub_q;
    mode_d = mode_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_REQ1;
          a_d = in_a;
          b_d = in_b;
          m_d = in_m;
          sub_d = subtract;
          mode_d = subtract;
        end
      S_REQ1: state_d = S_WAIT1;
      S_REQ2: state_d = S_WAIT2;
      S_WAIT1:
        if (add_done && (!mode_q || add_result[W])) begin
          state_d = S_REQ2;
          a_d = add_result[W-1:0];
          b_d = m_q;
          sub_d = !mode_q;
        end else if (add_done) begin
          state_d = S_FIN;
          res_d = add_result[W-1:0];
        end else if (expired) begin
          state_d = S_TO;
          res_d = '0;
        end
      S_WAIT2:
        if (add_done) begin
          state_d = S_FIN;
          res_d = (!mode_q && add_result[W]) ? a_q : add_result[W-1:0];
        end else if (expired) begin
          state_d = S_TO;
          res_d = '0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      res_q <= '0;
      sub_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      res_q <= res_d;
      sub_q <= sub_d;
      mode_q <= mode_d;
    end
  end
  assign result = res_q;
  assign done = state_q == S_FIN || state_q == S_TO;
  assign err = state_q == S_TO;
  assign busy = state_q != S_IDLE;
  assign add_start = state_q == S_REQ1 || state_q == S_REQ2;
  assign add_subtract = sub_q;
  assign add_a = a_q;
  assign add_b = b_q;
endmodule

// File: tb/tb_modadd_seq.sv
// tb_modadd_seq: directed scoreboard bench with behavioural adders at W=16 (variable L) and W=1027 (L=2)
module tb_modadd_seq;
  import modadd_seq_pkg::*;
  localparam int W = 16;
  localparam int WW = MP_W;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;

  logic start = 1'b0, subtract = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic [W-1:0] result, add_a, add_b;
  logic done, err, busy, add_start, add_subtract;
  logic [W:0] add_result = '0;
  logic add_done = 1'b0;

  logic start_w = 1'b0, subtract_w = 1'b0;
  logic [WW-1:0] in_a_w = '0, in_b_w = '0, in_m_w = '0;
  logic [WW-1:0] result_w, add_a_w, add_b_w;
  logic done_w, err_w, busy_w, add_start_w, add_subtract_w;
  logic [WW:0] add_result_w = '0;
  logic add_done_w = 1'b0, wd1 = 1'b0;

  modadd_seq #(.W(W), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
    .err(err), .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
    .add_a(add_a), .add_b(add_b), .add_result(add_result), .add_done(add_done)
  );

  modadd_seq dut_w (
    .clk(clk), .resetn(resetn), .start(start_w), .subtract(subtract_w),
    .in_a(in_a_w), .in_b(in_b_w), .in_m(in_m_w), .result(result_w), .done(done_w),
    .err(err_w), .busy(busy_w), .add_start(add_start_w), .add_subtract(add_subtract_w),
    .add_a(add_a_w), .add_b(add_b_w), .add_result(add_result_w), .add_done(add_done_w)
  );

  // narrow adder model: done L cycles after add_start, or never when hang is set
  int lat_l = 2;
  bit hang = 1'b0;
  int m_cnt = 0;
  bit m_busy = 1'b0;
  int nstart = 0;
  logic last_sub = 1'b0;
  logic [W-1:0] last_b = '0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (add_start === 1'b1) begin
      add_result <= add_subtract ? {1'b0, add_a} - {1'b0, add_b} : {1'b0, add_a} + {1'b0, add_b};
      nstart <= nstart + 1;
      last_sub <= add_subtract;
      last_b <= add_b;
      if (!hang) begin
        if (lat_l == 1) add_done <= 1'b1;
        else begin
          m_cnt <= lat_l - 1;
          m_busy <= 1'b1;
        end
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        add_done <= 1'b1;
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    wd1 <= add_start_w === 1'b1;
    add_done_w <= wd1;
    if (add_start_w === 1'b1)
      add_result_w <= add_subtract_w ? {1'b0, add_a_w} - {1'b0, add_b_w} : {1'b0, add_a_w} + {1'b0, add_b_w};
  end

  task automatic chk(input string tag, input logic [WW:0] obs, input logic [WW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic e;
    int lat;
    int t0;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (resetn && done === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done got done=1 expected no done");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("err", err, e.e);
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                       input logic s, input bit sc, input logic [W-1:0] r, input logic e, input int lat);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_m = m;
    subtract = s;
    start = 1'b1;
    if (sc) sb.push_back('{res: r, e: e, lat: lat, t0: cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wide_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [WW-1:0] m,
                         input logic s, input logic [WW-1:0] r, input string tag);
    int t0;
    @(negedge clk);
    in_a_w = a;
    in_b_w = b;
    in_m_w = m;
    subtract_w = s;
    start_w = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_w = 1'b0;
    for (int i = 0; i < 40 && done_w !== 1'b1; i++) @(negedge clk);
    chk({tag, "_done"}, done_w, 1'b1);
    chk({tag, "_result"}, result_w, r);
    chk({tag, "_err"}, err_w, 1'b0);
    chk({tag, "_latency"}, cyc - t0, 7);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [WW-1:0] mw, aw, bw;
    logic [WW:0] sw;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_subtract", add_subtract, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    resetn = 1'b1;
    @(negedge clk);

    n0 = nstart;
    pulse(9, 7, 13, 0, 1, 3, 0, 7);
    wait_idle("wrap_idle");
    chk("wrap_nreq", nstart - n0, 2);
    chk("wrap_op2_sub", last_sub, 1);
    chk("wrap_op2_b", last_b, 13);

    pulse(12, 1, 13, 0, 1, 0, 0, 7);
    wait_idle("eq_idle");
    pulse(5, 4, 13, 0, 1, 9, 0, 7);
    wait_idle("noneg_idle");

    n0 = nstart;
    pulse(3, 9, 13, 1, 1, 7, 0, 7);
    wait_idle("borrow_idle");
    chk("borrow_nreq", nstart - n0, 2);
    chk("borrow_op2_add", last_sub, 0);

    lat_l = 3;
    n0 = nstart;
    pulse(9, 3, 13, 1, 1, 6, 0, 5);
    wait_idle("noborrow_idle");
    chk("noborrow_nreq", nstart - n0, 1);

    lat_l = 5;
    pulse(10, 11, 13, 0, 1, 8, 0, 13);
    wait_idle("slow_idle");

    hang = 1'b1;
    n0 = nstart;
    pulse(1, 2, 13, 0, 1, 0, 1, 10);
    wait_idle("timeout_idle");
    chk("timeout_nreq", nstart - n0, 1);
    hang = 1'b0;
    lat_l = 2;
    pulse(4, 5, 13, 0, 1, 9, 0, 7);
    wait_idle("recover_idle");

    lat_l = 4;
    n0 = nstart;
    pulse(9, 3, 13, 1, 1, 6, 0, 6);
    @(negedge clk);
    in_a = 1;
    in_b = 2;
    subtract = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("overlap_idle");
    chk("overlap_nreq", nstart - n0, 1);
    chk("overlap_busy", busy, 0);

    n0 = nstart;
    pulse(9, 7, 13, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50 && nstart - n0 < 2; i++) @(negedge clk);
    chk("rst2_req2_seen", nstart - n0, 2);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst2_result", result, 0);
    chk("rst2_done", done, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_add_start", add_start, 0);
    chk("rst2_add_a", add_a, 0);
    chk("rst2_add_b", add_b, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst2_late_busy", busy, 0);
    chk("rst2_late_result", result, 0);
    lat_l = 2;
    pulse(3, 9, 13, 1, 1, 7, 0, 7);
    wait_idle("rst2_recover_idle");

    mw = '0;
    for (int i = 0; i < WW - 1; i++) mw[i] = 1'($urandom_range(1, 0));
    mw[WW-2] = 1'b1;
    aw = mw - 1;
    bw = mw >> 1;
    sw = {1'b0, aw} + {1'b0, bw};
    wide_op(aw, bw, mw, 0, (sw >= {1'b0, mw}) ? WW'(sw - {1'b0, mw}) : WW'(sw), "wide_add");
    wide_op(bw, aw, mw, 1, (bw >= aw) ? bw - aw : bw + mw - aw, "wide_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
